// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder controller.
// Encoding 2'd3 is illegal and recovers to S_IDLE.
package serial_adder_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Start/ready/done handshake and operand/result bus between a requester and serial_adder_ctrl.
// SERIAL_ADDER_SUB_EN adds the 'sub' request qualifier.
interface serial_adder_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b,
        input  ready, busy, done, sum, cout
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b,
        output ready, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder shared by every bit position of the serial adder.
module fa_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_z,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y ^ i_z;
    assign o_c = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: accept edge to done is W+1 cycles, one op per W+2 cycles; start ignored unless ready.
// SERIAL_ADDER_SUB_EN enables subtraction (b inverted, carry-in 1) selected by bus.sub at start.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_adder_if.slave    bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a_sr;
    logic [W-1:0]   r_b_sr;
    logic [W-1:0]   r_sum_sr;
    logic [W-1:0]   r_sum;
    logic           r_carry;
    logic           r_cout;
    logic [CW-1:0]  r_cnt;
    logic           w_s;
    logic           w_c;
    logic           w_sub;
    logic           w_last;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_last = (r_cnt == CW'(W - 1));

    fa_cell u_fa (
        .i_x (r_a_sr[0]),
        .i_y (r_b_sr[0]),
        .i_z (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= w_sub ? ~bus.b : bus.b;
                        r_carry <= w_sub;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= {w_s, r_sum_sr[W-1:1]};
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + CW'(1);
                    // Result registers load on the last bit so they are already valid while done=1.
                    if (w_last) begin
                        r_sum  <= {w_s, r_sum_sr[W-1:1]};
                        r_cout <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (r_state == ST_IDLE);
    assign bus.busy  = (r_state == ST_SHIFT);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.sum   = r_sum;
    assign bus.cout  = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: cycle-timeline reference model plus directed literal cases and random traffic.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_if #(.W(W)) bus ();

    serial_adder_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic fx, fy, fz, fs, fc;
    fa_cell u_fa_chk (.i_x(fx), .i_y(fy), .i_z(fz), .o_s(fs), .o_c(fc));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 = waiting, 1..W = bit cycles, W+1 = result cycle.
    int           m_phase = 0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    logic [W:0]   m_res   = '0;
    logic         m_sub;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
        end else if (m_phase == 0) begin
            if (bus.start === 1'b1) begin
`ifdef SERIAL_ADDER_SUB_EN
                m_sub = bus.sub;
`else
                m_sub = 1'b0;
`endif
                if (m_sub) m_res = {(bus.a >= bus.b), bus.a - bus.b};
                else       m_res = {1'b0, bus.a} + {1'b0, bus.b};
                m_phase = 1;
            end
        end else if (m_phase <= W) begin
            m_phase++;
            if (m_phase == W + 1) {m_cout, m_sum} = m_res;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        chk("ready", bus.ready, m_phase == 0);
        chk("busy",  bus.busy,  (m_phase >= 1) && (m_phase <= W));
        chk("done",  bus.done,  m_phase == W + 1);
        chk("sum",   bus.sum,   m_sum);
        chk("cout",  bus.cout,  m_cout);
    end

`ifdef SERIAL_ADDER_SUB_EN
    logic op_sub = 1'b0;
`endif

    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] xs, input logic xc);
        int n;
        int nbusy;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, bus.ready, 1);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = op_sub;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        n = 1;
        nbusy = 0;
        while (!bus.done && n < 4 * W) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, W + 1);
        chk({nm, "_busycycles"}, nbusy, W);
        chk({nm, "_sum"}, bus.sum, xs);
        chk({nm, "_cout"}, bus.cout, xc);
    endtask

    initial begin
        int dones;
        logic [W-1:0] cap_sum;
        logic cap_cout;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            {fx, fy, fz} = 3'(i);
            #1;
            chk("fa_s", fs, (fx + fy + fz) % 2);
            chk("fa_c", fc, (32'(fx) + 32'(fy) + 32'(fz)) >= 2);
        end

        @(negedge clk);
        chk("rst_ready", bus.ready, 1);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        #1 rst = 1'b0;

        do_op("add_100_55", 8'd100, 8'd55, 8'd155, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        do_op("add_0_0", 8'h00, 8'h00, 8'h00, 1'b0);

        // Second start while shifting must be ignored.
        do_op("pre_ignore", 8'h01, 8'h02, 8'h03, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'hBB;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; cap_sum = '0; cap_cout = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                cap_sum = bus.sum;
                cap_cout = bus.cout;
            end
        end
        chk("ignore_dones", dones, 1);
        chk("ignore_sum", cap_sum, 8'h46);
        chk("ignore_cout", cap_cout, 1'b0);

        // Reset in the 4th shift cycle aborts the op.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'hF1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_ready", bus.ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_sum", bus.sum, 0);
        chk("abort_cout", bus.cout, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_nodone", dones, 0);
        do_op("after_abort", 8'h80, 8'h90, 8'h10, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
        op_sub = 1'b1;
        do_op("sub_5_7", 8'd5, 8'd7, 8'hFE, 1'b0);
        do_op("sub_7_5", 8'd7, 8'd5, 8'h02, 1'b1);
        op_sub = 1'b0;
`endif

        // Random traffic, including starts that land while the block is busy.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            bus.sub   = 1'($urandom);
`endif
        end
        bus.start = 1'b0;
        repeat (2 * W) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
